// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes,
// ALU function codes and datapath select encodings.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_L   = 4'd6,
        S_EXE_BR = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] EXT_SA   = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_SIGN = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] REG_RA = 2'b00;
    localparam logic [1:0] REG_RT = 2'b01;
    localparam logic [1:0] REG_RD = 2'b10;

    // Register-writing ALU instructions that take the EXE_AL/WB_AL path.
    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND,
            OP_OR, OP_SLL, OP_MOVE, OP_SLT: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_if.sv
// Controller <-> datapath bundle: IR opcode, flags, memory handshake in;
// write enables, mux selects and status out.
interface multicycle_ctrl_hs_if #(parameter int ALUOP_W = 3);
    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               resume;
    logic               PCWre;
    logic               RegWre;
    logic               DataMemRW;
    logic               mem_req;
    logic               IRWre;
    logic               InsMemRW;
    logic               ALUSrcB;
    logic               ALUM2Reg;
    logic               WrRegData;
    logic [1:0]         ExtSel;
    logic [1:0]         PCSrc;
    logic [1:0]         RegOut;
    logic [ALUOP_W-1:0] ALUOp;
    logic               halted;
    logic               illegal_op;
    logic               bus_err;
    logic [3:0]         state;

    modport master (
        input  op, zero, mem_ready, resume,
        output PCWre, RegWre, DataMemRW, mem_req, IRWre, InsMemRW,
               ALUSrcB, ALUM2Reg, WrRegData, ExtSel, PCSrc, RegOut, ALUOp,
               halted, illegal_op, bus_err, state
    );

    modport slave (
        output op, zero, mem_ready, resume,
        input  PCWre, RegWre, DataMemRW, mem_req, IRWre, InsMemRW,
               ALUSrcB, ALUM2Reg, WrRegData, ExtSel, PCSrc, RegOut, ALUOp,
               halted, illegal_op, bus_err, state
    );
endinterface

// File: rtl/multicycle_ctrl_hs_decode.sv
// Combinational datapath decode: opcode and ALU zero flag to mux selects
// and ALU function.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         op,
    input  logic               zero,
    output logic               ALUSrcB,
    output logic               ALUM2Reg,
    output logic               WrRegData,
    output logic [1:0]         ExtSel,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegOut,
    output logic [ALUOP_W-1:0] ALUOp
);
    logic [2:0] alu_code;

    always_comb begin
        ALUSrcB   = 1'b0;
        ALUM2Reg  = 1'b0;
        WrRegData = 1'b1;
        ExtSel    = EXT_SA;
        PCSrc     = PC_SEQ;
        RegOut    = REG_RA;
        alu_code  = ALU_ADD;
        case (op)
            OP_ADD:  RegOut = REG_RD;
            OP_ADDI: begin RegOut = REG_RT; ALUSrcB = 1'b1; ExtSel = EXT_SIGN; end
            OP_SUB:  begin RegOut = REG_RD; alu_code = ALU_SUB; end
            OP_ORI:  begin RegOut = REG_RT; ALUSrcB = 1'b1; ExtSel = EXT_ZERO; alu_code = ALU_OR; end
            OP_AND:  begin RegOut = REG_RD; alu_code = ALU_AND; end
            OP_OR:   begin RegOut = REG_RD; alu_code = ALU_OR; end
            OP_SLL:  begin RegOut = REG_RD; ALUSrcB = 1'b1; ExtSel = EXT_SA; alu_code = ALU_SLL; end
            OP_MOVE: RegOut = REG_RD;
            OP_SLT:  begin RegOut = REG_RD; alu_code = ALU_SLT; end
            OP_SW:   begin ALUSrcB = 1'b1; ExtSel = EXT_SIGN; end
            OP_LW:   begin RegOut = REG_RT; ALUSrcB = 1'b1; ExtSel = EXT_SIGN; ALUM2Reg = 1'b1; end
            OP_BEQ:  begin ExtSel = EXT_SIGN; alu_code = ALU_SUB; PCSrc = zero ? PC_BR : PC_SEQ; end
            OP_J:    PCSrc = PC_JMP;
            OP_JR:   PCSrc = PC_JR;
            // Link register is written with PC+4 rather than an ALU result.
            OP_JAL:  begin PCSrc = PC_JMP; RegOut = REG_RA; WrRegData = 1'b0; end
            default: ;
        endcase
    end

    assign ALUOp = ALUOP_W'(alu_code);
endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle CPU control FSM with DM ready/timeout handshake, HALT/resume and
// illegal-opcode flagging. Optional perf counters under MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl_hs
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                reset,
    multicycle_ctrl_hs_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt
`endif
);
    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               pc_wre, reg_wre, ir_wre, mem_req, illegal, bus_err, halted;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        pc_wre     = 1'b0;
        reg_wre    = 1'b0;
        ir_wre     = 1'b0;
        mem_req    = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                op_d    = bus.op;
                state_d = S_ID;
            end
            S_ID: begin
                case (op_q)
                    OP_BEQ:        state_d = S_EXE_BR;
                    OP_SW, OP_LW:  state_d = S_EXE_LS;
                    OP_J, OP_JR:   begin pc_wre = 1'b1; state_d = S_IF; end
                    OP_JAL:        begin pc_wre = 1'b1; reg_wre = 1'b1; state_d = S_IF; end
                    OP_HALT:       state_d = S_HALT;
                    default: begin
                        if (is_alu_op(op_q)) begin
                            state_d = S_EXE_AL;
                        end else begin
                            // Unknown opcodes retire as a nop so the PC still advances.
                            illegal = 1'b1;
                            pc_wre  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  begin reg_wre = 1'b1; pc_wre = 1'b1; state_d = S_IF; end
            S_EXE_LS: begin wait_cnt_d = '0; state_d = S_MEM; end
            S_MEM: begin
                mem_req = 1'b1;
                // A completing access wins over a timeout in the same cycle.
                if (bus.mem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_wre  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB_L;
                    end
                end else if (wait_cnt_q == TMO_W'(MEM_TIMEOUT)) begin
                    bus_err = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB_L:   begin reg_wre = 1'b1; pc_wre = 1'b1; state_d = S_IF; end
            S_EXE_BR: begin pc_wre = 1'b1; state_d = S_IF; end
            S_HALT: begin
                halted = 1'b1;
                if (bus.resume) state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_IF;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // During IF the decode looks through to the live IR opcode.
    multicycle_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .op        ((state_q == S_IF) ? bus.op : op_q),
        .zero      (bus.zero),
        .ALUSrcB   (bus.ALUSrcB),
        .ALUM2Reg  (bus.ALUM2Reg),
        .WrRegData (bus.WrRegData),
        .ExtSel    (bus.ExtSel),
        .PCSrc     (bus.PCSrc),
        .RegOut    (bus.RegOut),
        .ALUOp     (bus.ALUOp)
    );

    assign bus.PCWre      = pc_wre;
    assign bus.RegWre     = reg_wre;
    assign bus.IRWre      = ir_wre;
    assign bus.mem_req    = mem_req;
    assign bus.DataMemRW  = mem_req && (op_q == OP_SW);
    assign bus.InsMemRW   = 1'b0;
    assign bus.halted     = halted;
    assign bus.illegal_op = illegal;
    assign bus.bus_err    = bus_err;
    assign bus.state      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q + {31'd0, pc_wre};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed bench for multicycle_ctrl_hs: walks each instruction class through
// the FSM and checks state, write enables and decode at every step.
module tb_multicycle_ctrl_hs;
    localparam logic [5:0] T_ADD = 6'b000000;
    localparam logic [5:0] T_ORI = 6'b010000;
    localparam logic [5:0] T_SW  = 6'b110000;
    localparam logic [5:0] T_LW  = 6'b110001;
    localparam logic [5:0] T_BEQ = 6'b110100;
    localparam logic [5:0] T_JAL = 6'b111010;
    localparam logic [5:0] T_BAD = 6'b101010;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_hs_if #(.ALUOP_W(3)) bus_if ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
    multicycle_ctrl_hs dut (.CLK(clk), .reset(reset), .bus(bus_if),
                            .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    multicycle_ctrl_hs dut (.CLK(clk), .reset(reset), .bus(bus_if));
`endif

    // {PCWre, RegWre, IRWre, mem_req, DataMemRW, halted, illegal_op, bus_err}
    wire [7:0] ctl = {bus_if.PCWre, bus_if.RegWre, bus_if.IRWre, bus_if.mem_req,
                      bus_if.DataMemRW, bus_if.halted, bus_if.illegal_op, bus_if.bus_err};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_if.op = T_ADD; bus_if.zero = 1'b0;
        bus_if.mem_ready = 1'b0; bus_if.resume = 1'b0;
        tick(); tick();
        checks++; if (bus_if.state !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus_if.state); end
        checks++; if (ctl !== 8'b0010_0000 || bus_if.InsMemRW !== 1'b0) begin errors++; $display("FAIL rst_ctl got=%b exp=00100000", ctl); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        bus_if.op = T_ADD;
        tick();
        checks++; if (bus_if.state !== 4'd1 || ctl !== 8'b0) begin errors++; $display("FAIL add_id got=%0d/%b exp=1/00000000", bus_if.state, ctl); end
        tick();
        checks++; if (bus_if.state !== 4'd2 || ctl !== 8'b0 || bus_if.RegOut !== 2'b10 || bus_if.ALUOp !== 3'b000) begin
            errors++; $display("FAIL add_exe got=%0d/%b/%b/%b exp=2/00000000/10/000", bus_if.state, ctl, bus_if.RegOut, bus_if.ALUOp); end
        tick();
        checks++; if (bus_if.state !== 4'd3 || ctl !== 8'b1100_0000 || bus_if.RegOut !== 2'b10) begin
            errors++; $display("FAIL add_wb got=%0d/%b/%b exp=3/11000000/10", bus_if.state, ctl, bus_if.RegOut); end
        tick();
        checks++; if (bus_if.state !== 4'd0 || ctl !== 8'b0010_0000) begin errors++; $display("FAIL add_back got=%0d/%b exp=0/00100000", bus_if.state, ctl); end
    endtask

    task automatic test_ori_decode();
        bus_if.op = T_ORI;
        tick(); tick();
        checks++; if ({bus_if.RegOut, bus_if.ALUSrcB, bus_if.ExtSel, bus_if.ALUOp} !== {2'b01, 1'b1, 2'b01, 3'b011}) begin
            errors++; $display("FAIL ori_dec got=%b%b%b%b exp=01101011", bus_if.RegOut, bus_if.ALUSrcB, bus_if.ExtSel, bus_if.ALUOp); end
        tick(); tick();
    endtask

    task automatic test_lw();
        int total = 1;
        int memc  = 0;
        bus_if.op = T_LW; bus_if.mem_ready = 1'b0;
        for (int i = 0; i < 20 && !(total > 1 && bus_if.state === 4'd0); i++) begin
            if (bus_if.state === 4'd5) begin
                memc++;
                if (ctl !== 8'b0001_0000) begin checks++; errors++; $display("FAIL lw_mem_ctl got=%b exp=00010000", ctl); end
                bus_if.mem_ready = (memc == 3);
            end else begin
                bus_if.mem_ready = 1'b0;
            end
            if (bus_if.state === 4'd6) begin
                checks++; if (ctl !== 8'b1100_0000 || bus_if.ALUM2Reg !== 1'b1) begin
                    errors++; $display("FAIL lw_wb got=%b/%b exp=11000000/1", ctl, bus_if.ALUM2Reg); end
            end
            tick();
            total++;
        end
        total--;
        checks++; if (memc != 3) begin errors++; $display("FAIL lw_mem_cycles got=%0d exp=3", memc); end
        checks++; if (total != 7) begin errors++; $display("FAIL lw_total got=%0d exp=7", total); end
    endtask

    task automatic test_sw_timeout();
        bit bad = 1'b0;
        bus_if.op = T_SW; bus_if.mem_ready = 1'b0;
        tick(); tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16 && (bus_if.state !== 4'd5 || ctl !== 8'b0001_1000)) bad = 1'b1;
            if (i == 16) begin
                checks++; if (bus_if.state !== 4'd5 || ctl !== 8'b0001_1001) begin
                    errors++; $display("FAIL sw_buserr got=%0d/%b exp=5/00011001", bus_if.state, ctl); end
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL sw_wait got=early_exit_or_bad_ctl exp=15_clean_mem_cycles"); end
        tick();
        checks++; if (bus_if.state !== 4'd8 || ctl !== 8'b0000_0100) begin errors++; $display("FAIL sw_halt got=%0d/%b exp=8/00000100", bus_if.state, ctl); end
        tick();
        checks++; if (bus_if.state !== 4'd8) begin errors++; $display("FAIL halt_hold got=%0d exp=8", bus_if.state); end
        bus_if.resume = 1'b1;
        tick();
        bus_if.resume = 1'b0;
        checks++; if (bus_if.state !== 4'd0 || ctl !== 8'b0010_0000) begin errors++; $display("FAIL resume got=%0d/%b exp=0/00100000", bus_if.state, ctl); end
    endtask

    task automatic test_beq();
        logic [1:0] exp_src;
        for (int z = 1; z >= 0; z--) begin
            bus_if.op = T_BEQ; bus_if.zero = z[0];
            exp_src = (z == 1) ? 2'b01 : 2'b00;
            tick(); tick();
            checks++; if (bus_if.state !== 4'd7 || ctl !== 8'b1000_0000 || bus_if.PCSrc !== exp_src) begin
                errors++; $display("FAIL beq_z%0d got=%0d/%b/%b exp=7/10000000/%b", z, bus_if.state, ctl, bus_if.PCSrc, exp_src); end
            tick();
            checks++; if (bus_if.state !== 4'd0) begin errors++; $display("FAIL beq_back_z%0d got=%0d exp=0", z, bus_if.state); end
        end
        bus_if.zero = 1'b0;
    endtask

    task automatic test_jal();
        bus_if.op = T_JAL;
        tick();
        checks++; if (bus_if.state !== 4'd1 || ctl !== 8'b1100_0000 || bus_if.WrRegData !== 1'b0 ||
                      bus_if.PCSrc !== 2'b11 || bus_if.RegOut !== 2'b00) begin
            errors++; $display("FAIL jal_id got=%b/%b/%b/%b exp=11000000/0/11/00", ctl, bus_if.WrRegData, bus_if.PCSrc, bus_if.RegOut); end
        tick();
        checks++; if (bus_if.state !== 4'd0) begin errors++; $display("FAIL jal_next got=%0d exp=0", bus_if.state); end
    endtask

    task automatic test_illegal();
        bus_if.op = T_BAD;
        tick();
        checks++; if (bus_if.state !== 4'd1 || ctl !== 8'b1000_0010) begin errors++; $display("FAIL illegal_id got=%0d/%b exp=1/10000010", bus_if.state, ctl); end
        tick();
        checks++; if (bus_if.state !== 4'd0 || ctl !== 8'b0010_0000) begin errors++; $display("FAIL illegal_pulse got=%0d/%b exp=0/00100000", bus_if.state, ctl); end
    endtask

    task automatic test_reset_mid_mem();
        bus_if.op = T_LW; bus_if.mem_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus_if.state !== 4'd5 || bus_if.mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem got=%0d/%b exp=5/1", bus_if.state, bus_if.mem_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus_if.state !== 4'd0 || ctl !== 8'b0010_0000) begin errors++; $display("FAIL rst_mem got=%0d/%b exp=0/00100000", bus_if.state, ctl); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ori_decode();
        test_lw();
        test_sw_timeout();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
